// File: rtl/floo_route_comp_seq.sv
// Sequential route computation: decodes one request against the address map and
// emits one destination beat per matching rule (unicast, serialised multicast, or error).
module floo_route_comp_seq #(
    parameter int NumAddrRules  = 4,
    parameter int NumRoutes     = 4,
    parameter int AddrWidth     = 32,
    parameter int IdWidth       = 4,
    parameter int RouteWidth    = 8,
    parameter int UseRouteTable = 1,
    localparam int CntWidth     = $clog2(NumAddrRules) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [AddrWidth-1:0]                   in_addr_i,
    input  logic [AddrWidth-1:0]                   in_mask_i,
    input  logic [IdWidth-1:0]                     in_src_id_i,
    input  logic [NumAddrRules-1:0][AddrWidth-1:0] rule_start_i,
    input  logic [NumAddrRules-1:0][AddrWidth-1:0] rule_end_i,
    input  logic [NumAddrRules-1:0][IdWidth-1:0]   rule_id_i,
    input  logic [NumRoutes-1:0][RouteWidth-1:0]   route_table_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [IdWidth-1:0]                     out_dst_id_o,
    output logic [IdWidth-1:0]                     out_src_id_o,
    output logic [RouteWidth-1:0]                  out_route_o,
    output logic                                   out_last_o,
    output logic [CntWidth-1:0]                    out_count_o,
    output logic                                   out_err_o
);

    typedef enum logic {IDLE, EMIT} state_e;

    localparam logic [NumAddrRules-1:0] PendOne = NumAddrRules'(1);

    state_e                  state_q, state_d;
    logic [NumAddrRules-1:0] pend_q, pend_d;
    logic [IdWidth-1:0]      src_q, src_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [NumAddrRules-1:0] match;
    logic [CntWidth-1:0]     match_cnt;
    logic                    uni_hit;
    logic [IdWidth-1:0]      cur_id;
    logic                    last_beat;

    // Unicast takes only the lowest matching range; multicast compares outside the mask.
    always_comb begin
        match     = '0;
        uni_hit   = 1'b0;
        match_cnt = '0;
        for (int i = 0; i < NumAddrRules; i++) begin
            if (in_mask_i == '0) begin
                if (!uni_hit && (rule_start_i[i] <= in_addr_i) && (in_addr_i < rule_end_i[i])) begin
                    match[i] = 1'b1;
                    uni_hit  = 1'b1;
                end
            end else begin
                match[i] = ((rule_start_i[i] ^ in_addr_i) & ~in_mask_i) == '0;
            end
            match_cnt = match_cnt + CntWidth'(match[i]);
        end
    end

    always_comb begin
        cur_id = '0;
        for (int i = NumAddrRules - 1; i >= 0; i--) begin
            if (pend_q[i]) cur_id = rule_id_i[i];
        end
        if (err_q) cur_id = '0;
    end

    assign last_beat = (pend_q & (pend_q - PendOne)) == '0;

    assign in_ready_o   = (state_q == IDLE) && !rst_i;
    assign out_valid_o  = (state_q == EMIT);
    assign out_dst_id_o = out_valid_o ? cur_id : '0;
    assign out_last_o   = out_valid_o && last_beat;
    assign out_err_o    = out_valid_o && err_q;
    assign out_count_o  = cnt_q;
    assign out_src_id_o = src_q;

    always_comb begin
        out_route_o = '0;
        if ((UseRouteTable != 0) && out_valid_o) begin
            for (int r = 0; r < NumRoutes; r++) begin
                if (int'(out_dst_id_o) == r) out_route_o = route_table_i[r];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = EMIT;
                    src_d   = in_src_id_i;
                    if (match == '0) begin
                        pend_d = PendOne;
                        cnt_d  = CntWidth'(1);
                        err_d  = 1'b1;
                    end else begin
                        pend_d = match;
                        cnt_d  = match_cnt;
                        err_d  = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    pend_d = pend_q & (pend_q - PendOne);
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
